// File: rtl/input_request_controller_if.sv
`default_nettype none
// ============================================================================
//  Module      : input_request_controller_if
//  Description : Bundle between the processor/board environment and the
//                input request controller (handshake, button, switches and
//                status outputs).
//  Revision    : 1.0 - initial release
// ============================================================================
interface input_request_controller_if #(
   parameter int DATA_W = 16,
   parameter int CNT_W  = 8
);
   logic              in_req;
   logic              in_cancel;
   logic              btn_clean;
   logic [DATA_W-1:0] switches;
   logic              db_reset;
   logic              in_ack;
   logic [DATA_W-1:0] in_data;
   logic              waiting;
   logic [CNT_W-1:0]  capture_cnt;

   // Environment side: processor control unit, debouncer and switch bank
   modport master (
      output in_req, in_cancel, btn_clean, switches,
      input  db_reset, in_ack, in_data, waiting, capture_cnt
   );

   // Controller side
   modport slave (
      input  in_req, in_cancel, btn_clean, switches,
      output db_reset, in_ack, in_data, waiting, capture_cnt
   );
endinterface
`default_nettype wire

// File: rtl/input_request_controller.sv
`default_nettype none
// ============================================================================
//  Module      : input_request_controller
//  Description : Sequences the debounced confirm button for processor IN
//                instructions: re-arms the debouncer, waits for a clean
//                press, captures the switch bank, waits for the release and
//                returns the word with a one-cycle acknowledge.
//  Revision    : 1.0 - initial release
// ============================================================================
module input_request_controller #(
   parameter int DATA_W = 16,
   parameter int CNT_W  = 8
) (
   input  logic                       clock,
   input  logic                       reset,
   input_request_controller_if.slave  bus
);

   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

   typedef enum logic [2:0] {
      IDLE       = 3'd0,
      ARM        = 3'd1,
      WAIT_LOW   = 3'd2,
      WAIT_PRESS = 3'd3,
      WAIT_REL   = 3'd4,
      ACK        = 3'd5,
      DONE       = 3'd6
   } state_t;

   state_t             state_q;
   state_t             state_d;
   logic               abort;
   logic               db_reset_q;
   logic               in_ack_q;
   logic               waiting_q;
   logic [DATA_W-1:0]  in_data_q;
   logic [CNT_W-1:0]   capture_cnt_q;

   // A dropped request counts the same as an explicit cancel while pending
   assign abort = bus.in_cancel || !bus.in_req;

   // Next-state selection; abort wins over any button activity in the same cycle
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:       if (bus.in_req && !bus.in_cancel) state_d = ARM;
         ARM:        state_d = abort ? IDLE : WAIT_LOW;
         WAIT_LOW:   if (abort) state_d = IDLE;
                     else if (!bus.btn_clean) state_d = WAIT_PRESS;
         WAIT_PRESS: if (abort) state_d = IDLE;
                     else if (bus.btn_clean) state_d = WAIT_REL;
         WAIT_REL:   if (abort) state_d = IDLE;
                     else if (!bus.btn_clean) state_d = ACK;
         ACK:        state_d = DONE;
         DONE:       if (!bus.in_req) state_d = IDLE;
         default:    state_d = IDLE;
      endcase
   end

   // State register plus outputs registered from the upcoming state so each
   // output is high exactly for the cycles spent in its state
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q       <= IDLE;
         db_reset_q    <= 1'b0;
         in_ack_q      <= 1'b0;
         waiting_q     <= 1'b0;
         in_data_q     <= '0;
         capture_cnt_q <= '0;
      end else begin
         state_q    <= state_d;
         db_reset_q <= (state_d == ARM);
         in_ack_q   <= (state_d == ACK);
         waiting_q  <= (state_d == ARM) || (state_d == WAIT_LOW) ||
                       (state_d == WAIT_PRESS) || (state_d == WAIT_REL);
         if (state_q == WAIT_PRESS && state_d == WAIT_REL)
            in_data_q <= bus.switches;
         if (state_q == WAIT_REL && state_d == ACK)
            capture_cnt_q <= capture_cnt_q + CNT_ONE;
      end
   end

   assign bus.db_reset    = db_reset_q;
   assign bus.in_ack      = in_ack_q;
   assign bus.waiting     = waiting_q;
   assign bus.in_data     = in_data_q;
   assign bus.capture_cnt = capture_cnt_q;

endmodule
`default_nettype wire
